// File: rtl/vid_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vid_frame_arbiter
//  Purpose  : Frame-aligned N:1 arbiter for Avalon-ST video streams. A grant is
//             taken only at a packet boundary. It is held across control/user
//             packets until the next video packet (type 0) has completed, so a
//             control packet always stays with its frame. The output is
//             registered, with one beat of latency.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock
//    rst_n        in   asynchronous active-low reset
//    cfg_mode_i   in   0 = fixed select, 1 = round-robin (sampled in IDLE)
//    cfg_sel_i    in   source index used in fixed mode (sampled in IDLE)
//    snk_valid_i  in   per-source valid
//    snk_sop_i    in   per-source start of packet
//    snk_eop_i    in   per-source end of packet
//    snk_data_i   in   per-source data, source i at [i*DW +: DW]
//    snk_ready_o  out  per-source ready
//    src_ready_i  in   downstream ready
//    src_valid_o  out  registered output valid
//    src_sop_o    out  registered output sop
//    src_eop_o    out  registered output eop
//    src_data_o   out  registered output data
//    grant_o      out  currently locked source
//    busy_o       out  high while a source is locked (state XFER)
//    frame_cnt_o  out  completed video packets, wraps at 16 bits
//    drop_cnt_o   out  orphan beats discarded in IDLE, saturating
//                      (present only when VID_ARB_DROP_CNT_EN is defined)
//  Build option : VID_ARB_DROP_CNT_EN
// ============================================================================
module vid_frame_arbiter #(
    parameter int N  = 2,
    parameter int DW = 24,
    parameter int SW = (N > 2) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_mode_i,
    input  logic [SW-1:0]   cfg_sel_i,
    input  logic [N-1:0]    snk_valid_i,
    input  logic [N-1:0]    snk_sop_i,
    input  logic [N-1:0]    snk_eop_i,
    input  logic [N*DW-1:0] snk_data_i,
    output logic [N-1:0]    snk_ready_o,
    input  logic            src_ready_i,
    output logic            src_valid_o,
    output logic            src_sop_o,
    output logic            src_eop_o,
    output logic [DW-1:0]   src_data_o,
    output logic [SW-1:0]   grant_o,
    output logic            busy_o,
    output logic [15:0]     frame_cnt_o
`ifdef VID_ARB_DROP_CNT_EN
    ,
    output logic [15:0]     drop_cnt_o
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t          state_q,     state_d;
    logic [SW-1:0]   grant_q,     grant_d;
    logic [SW-1:0]   last_q,      last_d;
    logic [3:0]      ptype_q,     ptype_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            src_valid_q, src_valid_d;
    logic            src_sop_q,   src_sop_d;
    logic            src_eop_q,   src_eop_d;
    logic [DW-1:0]   src_data_q,  src_data_d;

    logic            out_rdy;
    logic [N-1:0]    req;
    logic [N-1:0]    orphan;
    logic [N-1:0]    snk_ready;
    logic            win_found;
    logic [SW-1:0]   win_idx;
    logic [SW-1:0]   rr_idx;
    logic            g_valid;
    logic            g_sop;
    logic            g_eop;
    logic [DW-1:0]   g_data;
    logic            accept;
    logic [3:0]      eff_type;

    // Output register can take a beat when it is empty or being drained.
    assign out_rdy = src_ready_i | ~src_valid_q;
    assign req     = snk_valid_i & snk_sop_i;
    assign orphan  = snk_valid_i & ~snk_sop_i;

    // Winner selection for the IDLE state.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        if (!cfg_mode_i) begin
            // An out-of-range select simply never produces a grant.
            if (int'(cfg_sel_i) < N) begin
                if (req[cfg_sel_i]) begin
                    win_found = 1'b1;
                    win_idx   = cfg_sel_i;
                end
            end
        end else begin
            // Scan starts one past the last completed grant for fairness.
            for (int k = 1; k <= N; k++) begin
                rr_idx = SW'((int'(last_q) + k) % N);
                if (!win_found && req[rr_idx]) begin
                    win_found = 1'b1;
                    win_idx   = rr_idx;
                end
            end
        end
    end

    // Granted-source mux.
    always_comb begin
        g_valid = 1'b0;
        g_sop   = 1'b0;
        g_eop   = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == SW'(i)) begin
                g_valid = snk_valid_i[i];
                g_sop   = snk_sop_i[i];
                g_eop   = snk_eop_i[i];
                g_data  = snk_data_i[i*DW +: DW];
            end
        end
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        ptype_d     = ptype_q;
        frame_cnt_d = frame_cnt_q;
        src_valid_d = src_ready_i ? 1'b0 : src_valid_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        src_data_d  = src_data_q;
        snk_ready   = '0;
        accept      = 1'b0;
        eff_type    = ptype_q;

        case (state_q)
            S_IDLE: begin
                // Beats without sop are swallowed so a source can resync.
                // The arbitration cycle itself never moves a sop beat.
                snk_ready = orphan;
                if (win_found) begin
                    grant_d = win_idx;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                for (int i = 0; i < N; i++) begin
                    if (grant_q == SW'(i)) begin
                        snk_ready[i] = out_rdy;
                    end
                end
                accept = g_valid & out_rdy;
                if (accept) begin
                    src_valid_d = 1'b1;
                    src_sop_d   = g_sop;
                    src_eop_d   = g_eop;
                    src_data_d  = g_data;
                    // A sop beat carries its own type, including a single-beat
                    // packet, and also restarts a truncated packet.
                    if (g_sop) begin
                        eff_type = g_data[3:0];
                        ptype_d  = g_data[3:0];
                    end
                    if (g_eop && (eff_type == 4'd0)) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        last_d      = grant_q;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            last_q      <= SW'(N - 1);
            ptype_q     <= 4'd0;
            frame_cnt_q <= 16'd0;
            src_valid_q <= 1'b0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            ptype_q     <= ptype_d;
            frame_cnt_q <= frame_cnt_d;
            src_valid_q <= src_valid_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            src_data_q  <= src_data_d;
        end
    end

`ifdef VID_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    // Several sources may drop a beat in the same cycle; count each one.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < N; i++) begin
            if ((state_q == S_IDLE) && orphan[i]) begin
                drop_sum = drop_sum + 17'd1;
            end
        end
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

    assign snk_ready_o = snk_ready;
    assign src_valid_o = src_valid_q;
    assign src_sop_o   = src_sop_q;
    assign src_eop_o   = src_eop_q;
    assign src_data_o  = src_data_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != S_IDLE);
    assign frame_cnt_o = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vid_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vid_frame_arbiter
//  Purpose  : Directed self-checking bench for vid_frame_arbiter (N = 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vid_frame_arbiter;

    localparam int N  = 2;
    localparam int DW = 24;
    localparam int SW = 1;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [23:0] data;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_mode;
    logic [SW-1:0]   cfg_sel;
    logic [N-1:0]    snk_valid;
    logic [N-1:0]    snk_sop;
    logic [N-1:0]    snk_eop;
    logic [N*DW-1:0] snk_data;
    logic [N-1:0]    snk_ready;
    logic            src_ready;
    logic            src_valid;
    logic            src_sop;
    logic            src_eop;
    logic [DW-1:0]   src_data;
    logic [SW-1:0]   grant;
    logic            busy;
    logic [15:0]     frame_cnt;
`ifdef VID_ARB_DROP_CNT_EN
    logic [15:0]     drop_cnt;
`endif

    beat_t q0[$];
    beat_t q1[$];
    beat_t outq[$];
    beat_t expq[$];

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc;
    int    acc_cnt0;
    int    first_acc1;
    int    first_val;
    logic  rdy_toggle;
    logic  prev_v;
    logic  prev_r;
    beat_t prev_b;

    vid_frame_arbiter #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_mode_i  (cfg_mode),
        .cfg_sel_i   (cfg_sel),
        .snk_valid_i (snk_valid),
        .snk_sop_i   (snk_sop),
        .snk_eop_i   (snk_eop),
        .snk_data_i  (snk_data),
        .snk_ready_o (snk_ready),
        .src_ready_i (src_ready),
        .src_valid_o (src_valid),
        .src_sop_o   (src_sop),
        .src_eop_o   (src_eop),
        .src_data_o  (src_data),
        .grant_o     (grant),
        .busy_o      (busy),
        .frame_cnt_o (frame_cnt)
`ifdef VID_ARB_DROP_CNT_EN
        ,
        .drop_cnt_o  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input int s, input logic sop, input logic eop, input logic [23:0] d);
        beat_t b;
        b = {sop, eop, d};
        if (s == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic drive();
        if (q0.size() > 0) begin
            snk_valid[0] = 1'b1; snk_sop[0] = q0[0].sop; snk_eop[0] = q0[0].eop;
            snk_data[23:0] = q0[0].data;
        end else begin
            snk_valid[0] = 1'b0; snk_sop[0] = 1'b0; snk_eop[0] = 1'b0;
            snk_data[23:0] = '0;
        end
        if (q1.size() > 0) begin
            snk_valid[1] = 1'b1; snk_sop[1] = q1[0].sop; snk_eop[1] = q1[0].eop;
            snk_data[47:24] = q1[0].data;
        end else begin
            snk_valid[1] = 1'b0; snk_sop[1] = 1'b0; snk_eop[1] = 1'b0;
            snk_data[47:24] = '0;
        end
        src_ready = rdy_toggle ? ~src_ready : 1'b1;
    endtask

    // One clock: sample at the falling edge, drive just after the rising edge.
    task automatic step();
        beat_t cur;
        @(negedge clk);
        cur = {src_sop, src_eop, src_data};
        if (prev_v && !prev_r) begin
            check("hold_valid", 32'(src_valid), 32'd1);
            check("hold_data", 32'(cur), 32'(prev_b));
        end
        if (src_valid && src_ready) outq.push_back(cur);
        if (src_valid && first_val < 0) first_val = cyc;
        prev_v = src_valid;
        prev_r = src_ready;
        prev_b = cur;
        if (snk_valid[0] && snk_ready[0]) begin
            void'(q0.pop_front());
            acc_cnt0++;
        end
        if (snk_valid[1] && snk_ready[1]) begin
            void'(q1.pop_front());
            if (first_acc1 < 0) first_acc1 = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_drain(input logic [1:0] mask, input string tag);
        int n;
        n = 0;
        while (!(((!mask[0]) || q0.size() == 0) && ((!mask[1]) || q1.size() == 0) && !src_valid)
               && n < 300) begin
            step();
            n++;
        end
        check({tag, "_drain"}, 32'(n < 300), 32'd1);
        step();
        step();
    endtask

    task automatic new_test();
        outq.delete();
        expq.delete();
        first_acc1 = -1;
        first_val  = -1;
        acc_cnt0   = 0;
        cyc        = 0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        rdy_toggle = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        prev_v = 1'b0;
        prev_r = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cmp_out(input string tag);
        logic [31:0] act;
        check({tag, "_count"}, 32'(outq.size()), 32'(expq.size()));
        for (int k = 0; k < expq.size(); k++) begin
            act = (k < outq.size()) ? 32'(outq[k]) : 32'hFFFF_FFFF;
            check(tag, act, 32'(expq[k]));
        end
    endtask

    function automatic logic [23:0] mkv(input int s, input int f, input int i, input logic [3:0] t);
        return {4'(s), 4'(f), 8'h00, 4'(i), t};
    endfunction

    initial begin
        rst_n      = 1'b0;
        cfg_mode   = 1'b0;
        cfg_sel    = '0;
        rdy_toggle = 1'b0;
        src_ready  = 1'b1;
        snk_valid  = '0;
        snk_sop    = '0;
        snk_eop    = '0;
        snk_data   = '0;
        prev_v     = 1'b0;
        prev_r     = 1'b1;
        prev_b     = '0;
        new_test();
        repeat (3) @(posedge clk);
        #1;
        check("rst_src_valid", 32'(src_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_grant",     32'(grant),     32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;

        // Fixed select of source 1: control packet then video packet.
        new_test();
        cfg_mode = 1'b0;
        cfg_sel  = 1'b1;
        for (int s = 0; s < 2; s++) begin
            push(s, 1'b1, 1'b0, {4'(s), 16'h0000, 4'hF});
            push(s, 1'b0, 1'b1, {4'(s), 16'h0001, 4'h0});
            push(s, 1'b1, 1'b0, {4'(s), 16'h0002, 4'h0});
            push(s, 1'b0, 1'b0, {4'(s), 16'h0003, 4'h5});
            push(s, 1'b0, 1'b0, {4'(s), 16'h0004, 4'h5});
            push(s, 1'b0, 1'b1, {4'(s), 16'h0005, 4'hA});
        end
        expq = q1;
        drive();
        wait_drain(2'b10, "fixed");
        cmp_out("fixed_beat");
        check("fixed_src0_held", 32'(q0.size()), 32'd6);
        check("fixed_frame_cnt", 32'(frame_cnt), 32'd1);
        check("fixed_busy",      32'(busy),      32'd0);
        check("fixed_grant",     32'(grant),     32'd1);
        check("fixed_latency",   32'(first_val - first_acc1), 32'd1);

        // Round-robin with both sources offering frames back to back.
        do_reset();
        new_test();
        cfg_mode = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int s = 0; s < 2; s++) begin
                push(s, 1'b1, 1'b0, mkv(s, f, 0, 4'h0));
                push(s, 1'b0, 1'b0, mkv(s, f, 1, 4'h5));
                push(s, 1'b0, 1'b1, mkv(s, f, 2, 4'h5));
                expq.push_back({1'b1, 1'b0, mkv(s, f, 0, 4'h0)});
                expq.push_back({1'b0, 1'b0, mkv(s, f, 1, 4'h5)});
                expq.push_back({1'b0, 1'b1, mkv(s, f, 2, 4'h5)});
            end
        end
        drive();
        wait_drain(2'b11, "rr");
        cmp_out("rr_beat");
        check("rr_frame_cnt", 32'(frame_cnt), 32'd4);
        check("rr_busy",      32'(busy),      32'd0);

        // Downstream ready toggling every cycle.
        do_reset();
        new_test();
        cfg_mode = 1'b0;
        cfg_sel  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(0, i == 0, i == 4, mkv(0, 3, i, (i == 0) ? 4'h0 : 4'h7));
        end
        expq = q0;
        rdy_toggle = 1'b1;
        drive();
        wait_drain(2'b01, "toggle");
        rdy_toggle = 1'b0;
        cmp_out("toggle_beat");
        check("toggle_frame_cnt", 32'(frame_cnt), 32'd1);

        // Orphan beats in IDLE, then a normal frame.
        do_reset();
        new_test();
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, 1'b0, 24'hBAD000 | 24'(i));
        end
        push(0, 1'b1, 1'b0, mkv(0, 4, 0, 4'h0));
        push(0, 1'b0, 1'b1, mkv(0, 4, 1, 4'h3));
        expq.push_back({1'b1, 1'b0, mkv(0, 4, 0, 4'h0)});
        expq.push_back({1'b0, 1'b1, mkv(0, 4, 1, 4'h3)});
        drive();
        wait_drain(2'b01, "orphan");
        cmp_out("orphan_beat");
        check("orphan_accepted",  32'(acc_cnt0),  32'd5);
        check("orphan_frame_cnt", 32'(frame_cnt), 32'd1);
`ifdef VID_ARB_DROP_CNT_EN
        check("orphan_drop_cnt",  32'(drop_cnt),  32'd3);
`endif

        // Single-beat video packet.
        do_reset();
        new_test();
        push(0, 1'b1, 1'b1, 24'h000000);
        expq.push_back({1'b1, 1'b1, 24'h000000});
        drive();
        wait_drain(2'b01, "single");
        cmp_out("single_beat");
        check("single_frame_cnt", 32'(frame_cnt), 32'd1);
        check("single_busy",      32'(busy),      32'd0);

        // Reset in the middle of a frame; pointer returns to source 0 first.
        do_reset();
        new_test();
        cfg_mode = 1'b1;
        push(0, 1'b1, 1'b0, mkv(0, 5, 0, 4'h0));
        push(0, 1'b0, 1'b1, mkv(0, 5, 1, 4'h0));
        drive();
        wait_drain(2'b01, "pre_rst");
        check("pre_rst_frame_cnt", 32'(frame_cnt), 32'd1);
        new_test();
        for (int i = 0; i < 4; i++) begin
            push(0, i == 0, i == 3, mkv(0, 6, i, 4'h0));
        end
        drive();
        for (int n = 0; n < 50 && acc_cnt0 < 2; n++) step();
        check("mid_reached_beat2", 32'(acc_cnt0), 32'd2);
        check("mid_valid_before",  32'(src_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_src_valid", 32'(src_valid), 32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        q0.delete();
        q1.delete();
        drive();
        prev_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        new_test();
        push(0, 1'b1, 1'b0, mkv(0, 7, 0, 4'h0));
        push(0, 1'b0, 1'b1, mkv(0, 7, 1, 4'h5));
        push(1, 1'b1, 1'b0, mkv(1, 7, 0, 4'h0));
        push(1, 1'b0, 1'b1, mkv(1, 7, 1, 4'h5));
        expq.push_back({1'b1, 1'b0, mkv(0, 7, 0, 4'h0)});
        expq.push_back({1'b0, 1'b1, mkv(0, 7, 1, 4'h5)});
        expq.push_back({1'b1, 1'b0, mkv(1, 7, 0, 4'h0)});
        expq.push_back({1'b0, 1'b1, mkv(1, 7, 1, 4'h5)});
        drive();
        wait_drain(2'b11, "post_rst");
        cmp_out("post_rst_beat");
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vid_frame_arbiter.md
Name: vid_frame_arbiter

Overview:
- Frame-aligned N:1 arbiter for Avalon-ST video streams (24-bit RGB, sop/eop framed). Shares the single downstream video path between N upstream sources, e.g. live input vs. background/processed stream in the object-remover pipeline.
- Grants are taken only at packet boundaries. A grant persists across control/user packets until the following video packet (type 0) completes, so a control packet and its frame never separate.
- Output is registered: one beat of latency, same ready/valid rule as the other stream adapters.

Parameters:
- N, 2, number of sink ports (2..8).
- DW, 24, data width per beat.
- SW, $clog2(N) (min 1), width of select/grant fields (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_mode  in  1  0 = fixed select, 1 = round-robin.
- cfg_sel  in  SW  source index used in fixed mode.
- snk_valid  in  N  per-source valid.
- snk_sop  in  N  per-source start of packet.
- snk_eop  in  N  per-source end of packet.
- snk_data  in  N*DW  per-source data; source i occupies [i*DW +: DW].
- snk_ready  out  N  per-source ready.
- src_ready  in  1  downstream ready.
- src_valid  out  1  output valid (registered).
- src_sop  out  1  output sop (registered).
- src_eop  out  1  output eop (registered).
- src_data  out  DW  output data (registered).
- grant  out  SW  currently locked source.
- busy  out  1  high when state != IDLE.
- frame_cnt  out  16  completed video packets, wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async, rst_n low):
  - src_valid/sop/eop/data = 0; grant = 0; busy = 0; frame_cnt = 0; state = IDLE.
  - Round-robin pointer last = N-1, so the first round-robin grant goes to source 0.
  - Any packet in flight is abandoned; nothing is completed after reset.
- Output stage:
  - out_rdy = src_ready | ~src_valid.
  - Accepted beat (granted valid & ready): src_* loaded next edge.
  - Otherwise src_valid cleared when src_ready is high, held when src_ready is low.
  - Latency: 1 cycle from acceptance to src_valid.
- State IDLE:
  - Request from source i = snk_valid[i] & snk_sop[i].
  - Fixed mode: only cfg_sel may win. Round-robin: first requesting index after last, modulo N.
  - On a winner: grant <= winner; state -> XFER. No beat is accepted in the arbitration cycle; the sop beat transfers from the first XFER cycle.
  - Orphan beats (snk_valid & ~snk_sop) on any source: snk_ready = 1, beat discarded (resync).
  - Requesting (sop) but not-winning sources: snk_ready = 0, held.
  - cfg_mode and cfg_sel are sampled only in IDLE; mid-packet changes have no effect.
  - cfg_sel >= N: no grant, remain IDLE.
- State XFER:
  - snk_ready[grant] = out_rdy; all other snk_ready = 0.
  - On an accepted sop beat: ptype <= data[3:0].
  - On an accepted eop beat (including a single-beat sop & eop, using that beat's own type):
    - ptype == 0: frame_cnt++, last <= grant, state -> IDLE.
    - ptype != 0 (control/user): stay in XFER, locked to the same source.
  - A sop arriving before the eop of the current packet is forwarded as a new packet (truncation passes through unmodified) and ptype is recaptured.
  - Granted source idle (valid low): remain in XFER indefinitely, no timeout.
- Simultaneous events: eop acceptance and a new sop on another source in the same cycle resolve in the next IDLE cycle. Minimum one idle cycle between packets of different grants.

Optional Feature:
- VID_ARB_DROP_CNT_EN defined: adds output port drop_cnt (16 bits, reset 0). It increments once per orphan beat discarded in IDLE and saturates at 0xFFFF.
- Undefined: port and counter are absent; orphans are still discarded identically.

Test Plan:
- Fixed mode, cfg_sel = 1; both sources send control pkt (sop data 0x...F, 2 beats) then video pkt (sop 0x...0, 4 beats) -> only source 1's 6 beats appear on src, in order, 1-cycle latency; source 0 ready held 0; frame_cnt = 1; busy drops after video eop.
- Round-robin, both sources continuously offering 3-beat video frames -> grants alternate 0,1,0,1; frame_cnt = 4 after four frames; no interleaved beats within a packet.
- src_ready toggled 1/0 every cycle during a 5-beat frame -> no beat lost or duplicated; src_data holds while src_ready = 0 and src_valid = 1.
- In IDLE, source 0 drives 3 valid beats without sop, then a sop frame -> 3 beats discarded (ready = 1) and not output; drop_cnt = 3 when VID_ARB_DROP_CNT_EN is defined; the frame then forwards normally.
- Single-beat video packet (sop = eop = 1, data 0x000000) -> forwarded, frame_cnt++, return to IDLE.
- rst_n asserted mid-frame (beat 2 of 4) -> src_valid = 0 immediately, state IDLE, frame_cnt = 0; the next sop on source 0 is granted first.
